// File: rtl/uart_loopback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_loopback
//  Purpose  : 8N1 UART echo. Received bytes with a valid stop bit are held
//             and retransmitted unchanged on tx.
//  Options  : define LOOPBACK_FIFO_EN for a 4-entry FIFO in place of the
//             single overwrite-on-full holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_loopback #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // rx synchronizer
  logic rx_meta_q;
  logic rx_s_q;

  // receiver
  state_t           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]       rx_bit_q,   rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done_q,  rx_done_d;

  // transmitter
  state_t           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]       tx_bit_q,   tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q,       tx_d;

  // buffer interface
  logic       buf_avail;
  logic [7:0] buf_head;
  logic       tx_pop;

  assign tx_pop = (tx_state_q == ST_IDLE) && buf_avail;
  assign tx     = tx_q;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      ST_START: begin
        // Re-check mid start bit so short glitches are rejected
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Returning to IDLE mid stop bit lets the next start edge be caught
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_done_d  = rx_s_q;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Holding stage
  // --------------------------------------------------------------------------
`ifdef LOOPBACK_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q,  count_d;
  logic       push_ok;

  assign push_ok   = rx_done_q && (count_q != 3'd4);
  assign buf_avail = (count_q != 3'd0);
  assign buf_head  = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (tx_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  assign buf_avail = full_q;
  assign buf_head  = hold_q;

  // A byte landing while TX takes the old one keeps the flag set
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (tx_pop) begin
      full_d = 1'b0;
    end
    if (rx_done_q) begin
      hold_d = rx_shift_q;
      full_d = 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (buf_avail) begin
          tx_shift_d = buf_head;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef LOOPBACK_FIFO_EN
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`else
      hold_q <= '0;
      full_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef LOOPBACK_FIFO_EN
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`else
      hold_q <= hold_d;
      full_q <= full_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_loopback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_loopback
//  Purpose  : Directed self-checking bench for uart_loopback at 16 clk/bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loopback;

    localparam int CPB = 16;  // 1_600_000 / 100_000

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;

    always #5 clk = ~clk;

    uart_loopback #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .tx   (tx)
    );

    typedef struct {
        logic [7:0] data;
        logic       start_ok;
        logic       stop;
        time        t;
    } frame_t;

    frame_t frames[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    time    rx_start_t;
    time    rel_t;
    int     late;

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Decodes every frame seen on tx, sampling mid-bit
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                f.t = $time;
                repeat (CPB / 2 - 1) @(negedge clk);
                f.start_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.data[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                f.stop = tx;
                frames.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx         = 1'b0;
        rx_start_t = $time;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 3000 && frames.size() < n; k++) @(negedge clk);
        repeat (200) @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] seq [5];
        seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

        reset = 1'b1;
        rx    = 1'b1;
        #22;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) fail("reset_tx", tx, 1);
        repeat (300) @(negedge clk);
        n_cmp++; if (frames.size() !== 0) fail("idle_quiet", frames.size(), 0);

        // 0x55: data, framing and start-edge to start-edge latency
        send_byte(8'h55, 1'b1);
        wait_frames(1);
        n_cmp++; if (frames.size() !== 1) fail("b55_count", frames.size(), 1);
        n_cmp++; if (frames[0].data !== 8'h55) fail("b55_data", frames[0].data, 8'h55);
        n_cmp++; if (frames[0].start_ok !== 1'b1) fail("b55_start", frames[0].start_ok, 1);
        n_cmp++; if (frames[0].stop !== 1'b1) fail("b55_stop", frames[0].stop, 1);
        n_cmp++; if ((frames[0].t - rx_start_t) !== 64'd1570) fail("b55_latency_ns", frames[0].t - rx_start_t, 1570);
        frames.delete();

        send_byte(8'h00, 1'b1);
        wait_frames(1);
        n_cmp++; if (frames.size() !== 1) fail("b00_count", frames.size(), 1);
        n_cmp++; if (frames[0].data !== 8'h00) fail("b00_data", frames[0].data, 0);
        n_cmp++; if (frames[0].stop !== 1'b1) fail("b00_stop", frames[0].stop, 1);
        frames.delete();

        // Short low pulse must be rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        n_cmp++; if (frames.size() !== 0) fail("false_start", frames.size(), 0);

        // Bad stop bit discards the byte; next byte still echoes
        send_byte(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        wait_frames(1);
        n_cmp++; if (frames.size() !== 1) fail("frame_err_count", frames.size(), 1);
        n_cmp++; if (frames[0].data !== 8'h3C) fail("frame_err_next", frames[0].data, 8'h3C);
        frames.delete();

        for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
        wait_frames(5);
        n_cmp++; if (frames.size() !== 5) fail("b2b_count", frames.size(), 5);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (frames[i].data !== seq[i]) fail("b2b_data", frames[i].data, seq[i]);
        end
        frames.delete();

        // Reset in data bit 3 of an echoed 0x55
        send_byte(8'h55, 1'b1);
        for (int k = 0; k < 400 && ($time - rx_start_t) < 64'd2290; k++) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) fail("pre_reset_tx", tx, 0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) fail("reset_async_tx", tx, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rel_t = $time;
        repeat (400) @(negedge clk);
        late = 0;
        foreach (frames[i]) if (frames[i].t > rel_t) late++;
        n_cmp++; if (late !== 0) fail("no_residual", late, 0);
        frames.delete();

        send_byte(8'h3C, 1'b1);
        wait_frames(1);
        n_cmp++; if (frames.size() !== 1) fail("recover_count", frames.size(), 1);
        n_cmp++; if (frames[0].data !== 8'h3C) fail("recover_data", frames[0].data, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
